// File: rtl/duty_ramp_pkg.sv
// Shared definitions for the duty_ramp slew-rate limiter:
// duty width and the controller state encoding.
package duty_ramp_pkg;

  localparam int DUTY_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_STOP,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for the PWM tick. The input is sampled once and
// compared against the previous sample, so the one-cycle rise pulse
// appears the cycle after the input is first seen high.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sample_q, sample_d;
  logic prev_q, prev_d;

  // Next values: shift the sampled input through a two-stage history
  always_comb begin
    sample_d = sig;
    prev_d   = sample_q;
  end

  // History registers, cleared so no spurious edge follows reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
    end
  end

  assign rise = sample_q & ~prev_q;

endmodule

// File: rtl/duty_ramp.sv
// Duty-cycle slew limiter: moves the registered duty d toward a goal by at
// most STEP per PWM period, with soft stop when en drops.
// Optional watchdog enabled by defining DUTY_RAMP_WATCHDOG_EN.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int STEP        = 1,
  parameter int DMAX        = 100,
  parameter int WDOG_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] target,
  input  logic              tick,
  output logic [DUTY_W-1:0] d,
  output logic              ramping,
  output logic              at_target,
  output logic              fault
);

  localparam logic [DUTY_W-1:0] DMAX_V = DUTY_W'(DMAX);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(STEP);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] d_q, d_d;
  logic [DUTY_W-1:0] goal;
  logic [DUTY_W-1:0] d_stepped;
  logic [DUTY_W:0]   goal_x, d_x, diff_x;
  logic              step_evt;
  logic              wdog_expired;

  edge_rise u_edge_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (tick),
    .rise  (step_evt)
  );

  // Goal is the clamped target while running, zero when stopping
  always_comb begin
    goal = '0;
    if (en) begin
      goal = (target > DMAX_V) ? DMAX_V : target;
    end
  end

  // One bounded step toward the goal, in 11 bits so it can never wrap
  always_comb begin
    goal_x    = {1'b0, goal};
    d_x       = {1'b0, d_q};
    diff_x    = '0;
    d_stepped = d_q;
    if (goal_x >= d_x) begin
      diff_x = goal_x - d_x;
      if (diff_x <= STEP_X) begin
        d_stepped = goal;
      end else begin
        d_stepped = DUTY_W'(d_x + STEP_X);
      end
    end else begin
      diff_x = d_x - goal_x;
      if (diff_x <= STEP_X) begin
        d_stepped = goal;
      end else begin
        d_stepped = DUTY_W'(d_x - STEP_X);
      end
    end
  end

`ifdef DUTY_RAMP_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_active;

  // Count cycles without a step event while active; expire on the last one
  always_comb begin
    wdog_active  = (state_q == ST_RAMP) || (state_q == ST_HOLD) ||
                   (state_q == ST_STOP);
    wdog_d       = '0;
    wdog_expired = 1'b0;
    if (wdog_active && !step_evt) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_expired = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign fault = (state_q == ST_FAULT);
`else
  assign wdog_expired = 1'b0;
  assign fault        = 1'b0;
`endif

  // Next state and next duty; en is used directly so a stop request and a
  // step event in the same cycle already steps toward zero
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    unique case (state_q)
      ST_IDLE: begin
        d_d = '0;
        if (en) begin
          state_d = (goal != '0) ? ST_RAMP : ST_HOLD;
        end
      end
      ST_RAMP: begin
        if (step_evt) begin
          d_d = d_stepped;
        end
        if (!en) begin
          state_d = ST_STOP;
        end else if (step_evt && (d_stepped == goal)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (step_evt) begin
          d_d = d_stepped;
        end
        if (!en) begin
          state_d = ST_STOP;
        end else if (goal != d_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_STOP: begin
        if (step_evt) begin
          d_d = d_stepped;
        end
        if (en) begin
          state_d = ST_RAMP;
        end else if (d_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        d_d = '0;
        if (!en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        d_d     = '0;
      end
    endcase
    if (wdog_expired) begin
      state_d = ST_FAULT;
      d_d     = '0;
    end
  end

  // State and duty registers; reset drops the duty at once, no soft stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  assign d         = d_q;
  assign ramping   = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign at_target = (state_q == ST_HOLD);

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: one instance with STEP=1 and one with
// STEP=7 share clock, reset and tick. Watchdog checks follow
// DUTY_RAMP_WATCHDOG_EN.
module tb_duty_ramp;
  import duty_ramp_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              tick;
  logic              en_a, en_b;
  logic [DUTY_W-1:0] target_a, target_b;
  logic [DUTY_W-1:0] d_a, d_b;
  logic              ramping_a, ramping_b;
  logic              at_target_a, at_target_b;
  logic              fault_a, fault_b;

  int tests_run;
  int tests_failed;

  duty_ramp #(.STEP(1), .DMAX(100), .WDOG_CYCLES(256)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_a),
    .target    (target_a),
    .tick      (tick),
    .d         (d_a),
    .ramping   (ramping_a),
    .at_target (at_target_a),
    .fault     (fault_a)
  );

  duty_ramp #(.STEP(7), .DMAX(100), .WDOG_CYCLES(256)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_b),
    .target    (target_b),
    .tick      (tick),
    .d         (d_b),
    .ramping   (ramping_b),
    .at_target (at_target_b),
    .fault     (fault_b)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic check_output(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Run n PWM periods of 100 clk: tick high 50, low 50
  task automatic tick_periods(input int n);
    for (int p = 0; p < n; p++) begin
      tick = 1'b1;
      repeat (50) @(negedge clk);
      tick = 1'b0;
      repeat (50) @(negedge clk);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    target_a = '0;
    target_b = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("reset_d", 16'(d_a), 16'd0);
    check_output("reset_ramping", 16'(ramping_a), 16'd0);
    check_output("reset_at_target", 16'(at_target_a), 16'd0);
    check_output("reset_fault", 16'(fault_a), 16'd0);

    // Ramp 0 -> 5 one unit per period
    rst_n    = 1'b1;
    en_a     = 1'b1;
    target_a = 10'd5;
    @(negedge clk);
    check_output("start_ramping", 16'(ramping_a), 16'd1);
    check_output("start_d", 16'(d_a), 16'd0);
    for (int i = 1; i <= 5; i++) begin
      tick_periods(1);
      check_output($sformatf("ramp5_d%0d", i), 16'(d_a), 16'(i));
    end
    check_output("ramp5_at_target", 16'(at_target_a), 16'd1);
    check_output("ramp5_ramping", 16'(ramping_a), 16'd0);

    // Target above ceiling saturates at DMAX
    target_a = 10'd250;
    tick_periods(45);
    check_output("sat_mid_d", 16'(d_a), 16'd50);
    check_output("sat_mid_ramping", 16'(ramping_a), 16'd1);
    tick_periods(55);
    check_output("sat_d", 16'(d_a), 16'd100);
    check_output("sat_at_target", 16'(at_target_a), 16'd1);
    tick_periods(1);
    check_output("sat_nowrap_d", 16'(d_a), 16'd100);

    // Reverse to 60, soft stop, resume at 30, stop to idle
    target_a = 10'd60;
    tick_periods(40);
    check_output("down60_d", 16'(d_a), 16'd60);
    check_output("down60_at_target", 16'(at_target_a), 16'd1);
    en_a = 1'b0;
    @(negedge clk);
    check_output("stop_ramping", 16'(ramping_a), 16'd1);
    check_output("stop_at_target", 16'(at_target_a), 16'd0);
    tick_periods(30);
    check_output("stop30_d", 16'(d_a), 16'd30);
    en_a = 1'b1;
    @(negedge clk);
    tick_periods(1);
    check_output("resume_d", 16'(d_a), 16'd31);
    check_output("resume_ramping", 16'(ramping_a), 16'd1);
    en_a = 1'b0;
    tick_periods(31);
    check_output("idle_d", 16'(d_a), 16'd0);
    check_output("idle_ramping", 16'(ramping_a), 16'd0);
    check_output("idle_at_target", 16'(at_target_a), 16'd0);

    // en falls in the same cycle as a step event: step goes toward 0
    en_a     = 1'b1;
    target_a = 10'd3;
    @(negedge clk);
    tick_periods(3);
    check_output("hold3_d", 16'(d_a), 16'd3);
    check_output("hold3_at_target", 16'(at_target_a), 16'd1);
    tick = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check_output("same_cycle_d", 16'(d_a), 16'd2);
    check_output("same_cycle_ramping", 16'(ramping_a), 16'd1);
    repeat (48) @(negedge clk);
    tick = 1'b0;
    repeat (50) @(negedge clk);
    tick_periods(2);
    check_output("same_cycle_idle_d", 16'(d_a), 16'd0);
    check_output("same_cycle_idle_ramping", 16'(ramping_a), 16'd0);

    // Asynchronous reset mid-ramp
    en_a     = 1'b1;
    target_a = 10'd100;
    @(negedge clk);
    tick_periods(40);
    check_output("pre_reset_d", 16'(d_a), 16'd40);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_d", 16'(d_a), 16'd0);
    check_output("async_reset_ramping", 16'(ramping_a), 16'd0);
    @(negedge clk);
    en_a  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_d", 16'(d_a), 16'd0);

    // STEP=7: 0 -> 7 -> 10, then target 3 in one event
    en_b     = 1'b1;
    target_b = 10'd10;
    @(negedge clk);
    tick_periods(1);
    check_output("step7_first_d", 16'(d_b), 16'd7);
    tick_periods(1);
    check_output("step7_second_d", 16'(d_b), 16'd10);
    check_output("step7_at_target", 16'(at_target_b), 16'd1);
    target_b = 10'd3;
    @(negedge clk);
    check_output("step7_retarget_ramping", 16'(ramping_b), 16'd1);
    tick_periods(1);
    check_output("step7_reverse_d", 16'(d_b), 16'd3);
    check_output("step7_reverse_at_target", 16'(at_target_b), 16'd1);

    // Tick held low with en=1: watchdog trips after 256 active cycles
    en_b     = 1'b0;
    en_a     = 1'b1;
    target_a = 10'd50;
    repeat (256) @(negedge clk);
    check_output("wdog_before_fault", 16'(fault_a), 16'd0);
    @(negedge clk);
`ifdef DUTY_RAMP_WATCHDOG_EN
    check_output("wdog_fault", 16'(fault_a), 16'd1);
    check_output("wdog_fault_ramping", 16'(ramping_a), 16'd0);
`else
    check_output("nowdog_fault", 16'(fault_a), 16'd0);
    check_output("nowdog_ramping", 16'(ramping_a), 16'd1);
`endif
    check_output("wdog_d", 16'(d_a), 16'd0);
    en_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("wdog_exit_fault", 16'(fault_a), 16'd0);
    check_output("wdog_exit_ramping", 16'(ramping_a), 16'd0);
    check_output("wdog_exit_at_target", 16'(at_target_a), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
